uart_frame_tx_arbiter: RTL
==========================

// Module: uart_frame_tx_arbiter
// PURPOSE
//  Shares one "&&payload&&" UART string framer among N_REQ client blocks.
//  Grants clients round-robin, captures the granted string and length, and launches exactly one framer request.
//  Waits for frame completion, then acks the client; validates lengths and recovers from a stalled framer via watchdog.
//  Sits between application senders (measurement report, command reply, ...) and the framer's tx_* ports.
// PARAMETERS
//  N_REQ        4          number of clients (>=2)
//  STR_W        1096       payload bits per client; byte k = bits [8k+7:8k], byte 0 sent first
//  MAX_LEN      137        max payload bytes (STR_W/8)
//  TIMEOUT_CLK  2_000_000  clocks allowed from launch to frm_tx_done before abort
// PORTS
//  sys_clk        in   1              clock
//  sys_rst_n      in   1              async active-low reset
//  req_valid      in   N_REQ          client i wants to send; held high until req_ack[i]
//  req_string     in   N_REQ*STR_W    client i payload at [i*STR_W +: STR_W]; stable while req_valid[i]
//  req_length     in   N_REQ*8        client i byte count at [i*8 +: 8]
//  req_ack        out  N_REQ          1-cycle pulse: client i's request finished (sent or rejected)
//  req_err        out  N_REQ          1-cycle pulse with req_ack: length invalid or timeout
//  grant_idx      out  clog2(N_REQ)   index of client being served
//  arb_busy       out  1              high in every state except IDLE
//  frm_tx_string  out  STR_W          captured payload to framer
//  frm_tx_length  out  8              captured length to framer
//  frm_tx_req     out  1              1-cycle launch pulse to framer
//  frm_tx_busy    in   1              framer busy (high from cycle after frm_tx_req to end of frame)
//  frm_tx_done    in   1              framer 1-cycle pulse at frame end
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer = 0; state IDLE; timeout counter 0. Reset mid-frame aborts immediately (framer shares reset).
//  States:
//   IDLE    - if frm_tx_busy=0 and any req_valid: select first set bit scanning from ptr upward, mod N_REQ.
//             Latch grant_idx; capture string/length into frm_tx_* registers; go CHECK.
//   CHECK   - length==0 or >MAX_LEN: pulse req_ack/req_err[grant] -> IDLE, no launch, ptr advances.
//             Otherwise -> LAUNCH.
//   LAUNCH  - frm_tx_req=1 for this cycle only; clear timeout counter; -> WAIT.
//   WAIT    - count cycles. frm_tx_done=1 -> DONE.
//             Counter reaches TIMEOUT_CLK-1 without done -> pulse req_ack+req_err[grant] -> RECOVER.
//   DONE    - pulse req_ack[grant] (req_err=0); ptr <= grant+1 mod N_REQ; -> IDLE.
//   RECOVER - wait frm_tx_busy=0; ptr <= grant+1 mod N_REQ; -> IDLE.
//  Latency: req_valid rising in IDLE at cycle n -> frm_tx_req high at n+2; ack 1 cycle after frm_tx_done.
//  Back-to-back: same client holding req_valid after ack is re-eligible in the next IDLE, but only if no other client is pending.
//  Fairness: N clients continuously valid are served strictly in rotation.
//  frm_tx_string/length hold captured values from capture until the next capture; clients may change inputs after grant.
//  req_valid dropped after grant: frame still completes and req_ack still pulses.
//  frm_tx_done in any state other than WAIT: ignored.
//  Simultaneous frm_tx_done and timeout in the same WAIT cycle: done wins, no error.
//  Timeout counter width clog2(TIMEOUT_CLK+1); it saturates and does not wrap.
//  At most one bit of req_ack ever set; req_err only ever set together with the matching req_ack bit.
// TESTING
//  1 Client1 len=3 payload "ABC" (byte0='A'), framer model 500-clk frame -> frm_tx_req once at n+2,
//    frm_tx_length=3, frm_tx_string[7:0]=8'h41; req_ack[1] 1 clk after done; req_err=0.
//  2 All 4 valid held, len=1 -> launches in order 0,1,2,3,0; no overlap of frm_tx_req with frm_tx_busy.
//  3 Client2 len=0, then client3 len=138 -> each gets req_ack+req_err pulse, no frm_tx_req, ptr advances.
//  4 TIMEOUT_CLK=100, framer never pulses done, busy held 50 more clks -> ack+err at launch+100;
//    arb_busy low only after busy falls.
//  5 Reset asserted in WAIT -> all outputs 0 same cycle; after release client2-only request is served (ptr=0 scan).
//  6 Client3 waiting while client0 re-asserts immediately after its ack -> client3 served before client0.

Source files
------------

// File: rtl/uart_frame_tx_arbiter.sv
// uart_frame_tx_arbiter
//   Shares one "&&payload&&" UART string framer between N_REQ clients.
//   Clients are granted round-robin. The granted string and length are
//   captured, validated, and then launched to the framer with a single-cycle
//   request. The client is acked when the framer reports frame completion.
//   A watchdog aborts frames that never complete, and waits for the framer
//   to go idle before the next client is granted.
//
// Ports
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   req_valid   [N_REQ]        client i wants to send (held until req_ack[i])
//   req_string  [N_REQ*STR_W]  client i payload at [i*STR_W +: STR_W]
//   req_length  [N_REQ*8]      client i byte count at [i*8 +: 8]
//   req_ack     [N_REQ]        1-cycle pulse: client request finished
//   req_err     [N_REQ]        1-cycle pulse with req_ack: bad length or timeout
//   grant_idx                  client currently being served
//   arb_busy                   high whenever the arbiter is not idle
//   frm_tx_string/length       captured payload and length to the framer
//   frm_tx_req                 1-cycle launch pulse to the framer
//   frm_tx_busy, frm_tx_done   framer status inputs
module uart_frame_tx_arbiter #(
  parameter int  N_REQ       = 4,
  parameter int  STR_W       = 1096,
  parameter int  MAX_LEN     = 137,
  parameter int  TIMEOUT_CLK = 2_000_000,
  localparam int IDX_W       = $clog2(N_REQ)
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*STR_W-1:0]   req_string,
  input  logic [N_REQ*8-1:0]       req_length,
  output logic [N_REQ-1:0]         req_ack,
  output logic [N_REQ-1:0]         req_err,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     arb_busy,
  output logic [STR_W-1:0]         frm_tx_string,
  output logic [7:0]               frm_tx_length,
  output logic                     frm_tx_req,
  input  logic                     frm_tx_busy,
  input  logic                     frm_tx_done
);

  localparam int CNT_W = $clog2(TIMEOUT_CLK + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LAUNCH,
    WAIT,
    DONE,
    RECOVER
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   grant_reg;
  logic [STR_W-1:0]   str_reg;
  logic [7:0]         len_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   ptr_next;
  logic               capture;
  logic               advance;
  logic               cnt_clear;
  logic               ack_pulse;
  logic               err_pulse;
  logic               tx_req;
  logic               len_bad;

  logic [STR_W-1:0]   str_arr [N_REQ];
  logic [7:0]         len_arr [N_REQ];

  // Unpack the flat client buses and decode the per-client ack/err pulses
  // from the registered grant, so at most one client can ever see an ack.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_client
    assign str_arr[gi] = req_string[gi*STR_W +: STR_W];
    assign len_arr[gi] = req_length[gi*8 +: 8];
    assign req_ack[gi] = ack_pulse && (grant_reg == IDX_W'(gi));
    assign req_err[gi] = err_pulse && (grant_reg == IDX_W'(gi));
  end

  // Round-robin select: the first valid client at or after ptr_reg, wrapping.
  // The loop runs from the farthest candidate down, so the nearest one wins.
  always_comb begin
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] cand_idx;
    sel_idx  = '0;
    cand     = '0;
    cand_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      cand_idx = cand[IDX_W-1:0];
      if (req_valid[cand_idx]) begin
        sel_idx = cand_idx;
      end
    end
  end

  // The pointer always moves to the client after the one just served.
  always_comb begin
    if (grant_reg == IDX_W'(N_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_reg + IDX_W'(1);
    end
  end

  assign len_bad = (len_reg == 8'd0) || (int'({24'd0, len_reg}) > MAX_LEN);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    advance    = 1'b0;
    cnt_clear  = 1'b0;
    ack_pulse  = 1'b0;
    err_pulse  = 1'b0;
    tx_req     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!frm_tx_busy && (|req_valid)) begin
          capture    = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (len_bad) begin
          ack_pulse  = 1'b1;
          err_pulse  = 1'b1;
          advance    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_req     = 1'b1;
        cnt_clear  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        // A done arriving on the final allowed cycle still counts as success.
        if (frm_tx_done) begin
          state_next = DONE;
        end else if (cnt_reg >= CNT_W'(TIMEOUT_CLK - 1)) begin
          ack_pulse  = 1'b1;
          err_pulse  = 1'b1;
          state_next = RECOVER;
        end
      end
      DONE: begin
        ack_pulse  = 1'b1;
        advance    = 1'b1;
        state_next = IDLE;
      end
      RECOVER: begin
        // The client is already acked; only hold off new grants until the
        // stalled framer lets go of its busy flag.
        if (!frm_tx_busy) begin
          advance    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ptr_reg   <= '0;
      grant_reg <= '0;
      str_reg   <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      if (capture) begin
        grant_reg <= sel_idx;
        str_reg   <= str_arr[sel_idx];
        len_reg   <= len_arr[sel_idx];
      end
      if (advance) begin
        ptr_reg <= ptr_next;
      end
      if (cnt_clear) begin
        cnt_reg <= '0;
      end else if ((state_reg == WAIT) && (cnt_reg != CNT_W'(TIMEOUT_CLK))) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign grant_idx     = grant_reg;
  assign arb_busy      = (state_reg != IDLE);
  assign frm_tx_string = str_reg;
  assign frm_tx_length = len_reg;
  assign frm_tx_req    = tx_req;

endmodule
